// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;
  typedef enum logic {IDLE, BURST} state_e;

  localparam logic        PORT_P0    = 1'b0;
  localparam logic        PORT_P1    = 1'b1;
  localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/dmem_arb_beat_ctr.sv
// Burst sequencer for the p1 port: latches base/len on load and steps the word
// address once per issued beat, flagging the final beat.
module dmem_arb_beat_ctr
  import dmem_arb_pkg::*;
#(
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [31:0]      base,
  input  logic [LEN_W-1:0] len,
  input  logic             beat_issue,
  output logic [31:0]      beat_addr,
  output logic             last_beat,
  output logic             advance
);

  logic [31:0]      addr_q;
  logic [LEN_W-1:0] k_q;
  logic [LEN_W-1:0] len_q;
  logic             active_q;

  assign advance   = beat_issue && active_q;
  assign last_beat = active_q && (k_q == (len_q - LEN_W'(1)));
  assign beat_addr = addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q      <= '0;
      len_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      k_q      <= '0;
      len_q    <= len;
      active_q <= (len != '0);
    end else if (advance) begin
      k_q <= k_q + LEN_W'(1);
      if (last_beat) active_q <= 1'b0;
    end
  end

  // Address is pure data: it is only observed while a burst is active.
  always_ff @(posedge clk) begin
    if (load)         addr_q <= base;
    else if (advance) addr_q <= addr_q + WORD_BYTES;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between CPU port p0 and burst DMA port p1.
// Define DMEM_ARB_RR_EN for round-robin in IDLE; default is fixed p0 priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [31:0]      p0_addr,
  input  logic [31:0]      p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic [31:0]      p0_rdata,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [31:0]      p1_addr,
  input  logic [LEN_W-1:0] p1_len,
  output logic             p1_gnt,
  input  logic             p1_wvalid,
  input  logic [31:0]      p1_wdata,
  output logic             p1_wready,
  output logic             p1_rvalid,
  output logic [31:0]      p1_rdata,
  output logic             p1_done,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [31:0]      mem_dout,
  output logic             busy
);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l > LEN_W'(MAX_BURST)) return LEN_W'(MAX_BURST);
    return l;
  endfunction

  state_e           state_q, state_d;
  logic             burst_we_q;
  logic             p0_win, p1_win;
  logic             load, beat_issue, p0_rd, p1_rd, done_set;
  logic [LEN_W-1:0] len_clamped;
  logic [31:0]      beat_addr;
  logic             last_beat, advance;

  assign len_clamped = clamp_len(p1_len);
  assign beat_issue  = reset_n && (state_q == BURST) && (!burst_we_q || p1_wvalid);
  assign busy        = (state_q == BURST);

`ifdef DMEM_ARB_RR_EN
  logic last_gnt_q;

  always_comb begin
    p0_win = p0_req;
    p1_win = p1_req && !p0_req;
    if (p0_req && p1_req) begin
      p0_win = (last_gnt_q == PORT_P1);
      p1_win = (last_gnt_q == PORT_P0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last_gnt_q <= PORT_P0;
    else if (p0_gnt) last_gnt_q <= PORT_P0;
    else if (p1_gnt) last_gnt_q <= PORT_P1;
  end
`else
  assign p0_win = p0_req;
  assign p1_win = p1_req && !p0_req;
`endif

  dmem_arb_beat_ctr #(.LEN_W(LEN_W)) u_beat_ctr (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .base       (p1_addr),
    .len        (len_clamped),
    .beat_issue (beat_issue),
    .beat_addr  (beat_addr),
    .last_beat  (last_beat),
    .advance    (advance)
  );

  // Grant decode and memory-side mux; everything idles while reset_n is low.
  always_comb begin
    state_d   = state_q;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p1_wready = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    load      = 1'b0;
    p0_rd     = 1'b0;
    p1_rd     = 1'b0;
    done_set  = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (p0_win) begin
            p0_gnt   = 1'b1;
            mem_addr = p0_addr;
            if (p0_we) begin
              mem_write = 1'b1;
              mem_din   = p0_wdata;
            end else begin
              mem_read = 1'b1;
              p0_rd    = 1'b1;
            end
          end else if (p1_win) begin
            p1_gnt = 1'b1;
            load   = 1'b1;
            if (len_clamped == '0) done_set = 1'b1;
            else                   state_d  = BURST;
          end
        end
        BURST: begin
          if (beat_issue) begin
            mem_addr = beat_addr;
            if (burst_we_q) begin
              mem_write = 1'b1;
              p1_wready = 1'b1;
              mem_din   = p1_wdata;
            end else begin
              mem_read = 1'b1;
              p1_rd    = 1'b1;
            end
          end
          if (advance && last_beat) begin
            state_d  = IDLE;
            done_set = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Response stage: read data and strobes one cycle after the access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      burst_we_q <= 1'b0;
      p0_rvalid  <= 1'b0;
      p0_rdata   <= '0;
      p1_rvalid  <= 1'b0;
      p1_rdata   <= '0;
      p1_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p0_rvalid <= p0_rd;
      p1_rvalid <= p1_rd;
      p1_done   <= done_set;
      if (load)  burst_we_q <= p1_we;
      if (p0_rd) p0_rdata   <= mem_dout;
      if (p1_rd) p1_rdata   <= mem_dout;
    end
  end

endmodule
